// File: rtl/axi_mtimer_slave.sv
// rtl/axi_mtimer_slave.sv - AXI4-Lite machine timer (mtime/mtimecmp) responder with interrupt
module axi_mtimer_slave #(
    parameter int          ADDR_W       = 6,
    parameter logic [15:0] PRESCALE_RST = 16'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        axi_awvalid_i,
    input  logic [31:0] axi_awaddr_i,
    output logic        axi_awready_o,
    input  logic        axi_wvalid_i,
    input  logic [31:0] axi_wdata_i,
    input  logic [3:0]  axi_wstrb_i,
    output logic        axi_wready_o,
    output logic        axi_bvalid_o,
    output logic [1:0]  axi_bresp_o,
    input  logic        axi_bready_i,
    input  logic        axi_arvalid_i,
    input  logic [31:0] axi_araddr_i,
    output logic        axi_arready_o,
    output logic        axi_rvalid_o,
    output logic [31:0] axi_rdata_o,
    output logic [1:0]  axi_rresp_o,
    input  logic        axi_rready_i,
    output logic        timer_irq_o
);

    localparam int OFF_W = ADDR_W - 2;

    localparam logic [OFF_W-1:0] OFF_MTIME_LO = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_MTIME_HI = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_CMP_LO   = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_CMP_HI   = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_CTRL     = OFF_W'(4);
    localparam logic [OFF_W-1:0] OFF_PRESCALE = OFF_W'(5);

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        w_state;
    logic        r_state;
    logic [1:0]  bresp_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        ctrl_en;
    logic [15:0] prescale;
    logic [15:0] presc_cnt;
    logic [31:0] hi_shadow;
    logic        irq_q;

    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] rd_off;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_mtime_lo;
    logic             wr_mtime_hi;
    logic             wr_cmp_lo;
    logic             wr_cmp_hi;
    logic             wr_ctrl;
    logic             wr_prescale;
    logic             wr_hit;
    logic             clr;
    logic             tick;
    logic [31:0]      mtime_lo_new;
    logic [31:0]      mtime_hi_new;
    logic [31:0]      cmp_lo_new;
    logic [31:0]      cmp_hi_new;
    logic [31:0]      rd_data;
    logic             rd_ok;
    logic             unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    // Upper address bits are not decoded and word alignment is assumed.
    assign unused_addr_bits = ^{axi_awaddr_i[31:ADDR_W], axi_awaddr_i[1:0],
                                axi_araddr_i[31:ADDR_W], axi_araddr_i[1:0]};

    assign wr_off = axi_awaddr_i[ADDR_W-1:2];
    assign rd_off = axi_araddr_i[ADDR_W-1:2];

    // Address and data must arrive together; both are taken in the same cycle.
    assign wr_fire = rst_ni && (w_state == W_IDLE) && axi_awvalid_i && axi_wvalid_i;
    assign rd_fire = axi_arvalid_i && axi_arready_o;

    assign wr_mtime_lo = wr_fire && (wr_off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr_fire && (wr_off == OFF_MTIME_HI);
    assign wr_cmp_lo   = wr_fire && (wr_off == OFF_CMP_LO);
    assign wr_cmp_hi   = wr_fire && (wr_off == OFF_CMP_HI);
    assign wr_ctrl     = wr_fire && (wr_off == OFF_CTRL);
    assign wr_prescale = wr_fire && (wr_off == OFF_PRESCALE);
    assign wr_hit      = wr_mtime_lo || wr_mtime_hi || wr_cmp_lo || wr_cmp_hi ||
                         wr_ctrl || wr_prescale;
    assign clr         = wr_ctrl && axi_wstrb_i[0] && axi_wdata_i[1];
    assign tick        = ctrl_en && (presc_cnt == prescale);

    assign mtime_lo_new = merge_bytes(mtime[31:0],     axi_wdata_i, axi_wstrb_i);
    assign mtime_hi_new = merge_bytes(mtime[63:32],    axi_wdata_i, axi_wstrb_i);
    assign cmp_lo_new   = merge_bytes(mtimecmp[31:0],  axi_wdata_i, axi_wstrb_i);
    assign cmp_hi_new   = merge_bytes(mtimecmp[63:32], axi_wdata_i, axi_wstrb_i);

    // Read data mux; MTIME_HI returns the value latched by the last MTIME_LO read.
    always_comb begin
        rd_data = 32'd0;
        rd_ok   = 1'b1;
        case (rd_off)
            OFF_MTIME_LO: rd_data = mtime[31:0];
            OFF_MTIME_HI: rd_data = hi_shadow;
            OFF_CMP_LO:   rd_data = mtimecmp[31:0];
            OFF_CMP_HI:   rd_data = mtimecmp[63:32];
            OFF_CTRL:     rd_data = {31'd0, ctrl_en};
            OFF_PRESCALE: rd_data = {16'd0, prescale};
            default:      rd_ok   = 1'b0;
        endcase
    end

    // Write channel: accept in idle, then hold the response until bready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else if (w_state == W_IDLE) begin
            if (wr_fire) begin
                w_state <= W_RESP;
                bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end else if (axi_bready_i) begin
            w_state <= W_IDLE;
        end
    end

    // Read channel: capture data at accept, hold it until rready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= R_IDLE;
            rdata_q <= 32'd0;
            rresp_q <= RESP_OKAY;
        end else if (r_state == R_IDLE) begin
            if (rd_fire) begin
                r_state <= R_DATA;
                rdata_q <= rd_data;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end else if (axi_rready_i) begin
            r_state <= R_IDLE;
        end
    end

    // Latch the upper mtime half alongside a low-half read for atomic 64-bit reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_shadow <= 32'd0;
        end else if (rd_fire && (rd_off == OFF_MTIME_LO)) begin
            hi_shadow <= mtime[63:32];
        end
    end

    // Prescaler: mtime advances once every PRESCALE+1 enabled clocks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_cnt <= 16'd0;
        end else if (clr || wr_prescale) begin
            presc_cnt <= 16'd0;
        end else if (ctrl_en) begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
        end
    end

    // mtime: bus writes and CLR take precedence; a tick in that cycle is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime <= 64'd0;
        end else if (clr) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo || wr_mtime_hi) begin
            mtime <= {wr_mtime_hi ? mtime_hi_new : mtime[63:32],
                      wr_mtime_lo ? mtime_lo_new : mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Compare, enable and prescale registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_en  <= 1'b0;
            prescale <= PRESCALE_RST;
        end else begin
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= cmp_lo_new;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= cmp_hi_new;
            end
            if (wr_ctrl && axi_wstrb_i[0]) begin
                ctrl_en <= axi_wdata_i[0];
            end
            if (wr_prescale && axi_wstrb_i[0]) begin
                prescale[7:0] <= axi_wdata_i[7:0];
            end
            if (wr_prescale && axi_wstrb_i[1]) begin
                prescale[15:8] <= axi_wdata_i[15:8];
            end
        end
    end

    // Level interrupt, registered one cycle behind the compare.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_en && (mtime >= mtimecmp);
        end
    end

    assign axi_awready_o = wr_fire;
    assign axi_wready_o  = wr_fire;
    assign axi_bvalid_o  = (w_state == W_RESP);
    assign axi_bresp_o   = bresp_q;
    assign axi_arready_o = rst_ni && (r_state == R_IDLE);
    assign axi_rvalid_o  = (r_state == R_DATA);
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = rresp_q;
    assign timer_irq_o   = irq_q;

endmodule
